// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit multiplexed BCD display.
package bcd_disp_pkg;

  localparam int DIGIT_W = 4;
  localparam int WORD_W  = 5;

  // Slot sequence of one display frame.
  typedef enum logic [1:0] {
    GAP_U = 2'd0,
    UNITS = 2'd1,
    GAP_T = 2'd2,
    TENS  = 2'd3
  } disp_state_t;

  // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_E   = 7'b1111001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to seven-segment pattern (active-high), "E" above 9.
module seg7_encode
  import bcd_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         pattern
);

  // Table lookup; any non-decimal nibble shows the error glyph.
  always_comb begin
    pattern = SEG_E;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit time-multiplexed seven-segment driver. A value captured by load
// waits in a pending register and is only committed at the start of a frame,
// so a digit pair is never shown half old / half new. Dead-time slots sit
// between the digits to suppress ghosting.
module bcd_display_mux
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int GAP_CYCLES     = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] bcd_in,
  input  logic              load,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic [1:0]        an,
  output logic              bcd_err,
  output logic              frame_start
);

  localparam int MAX_CNT = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] REFRESH_LD = CNT_W'(REFRESH_DIV);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYCLES);

  disp_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              expire;
  logic              commit;

  logic [WORD_W-1:0] pending;
  logic              pending_valid;
  logic [WORD_W-1:0] committed;

  logic [DIGIT_W-1:0] digit_sel;
  logic [6:0]         pattern;
  logic [6:0]         seg_hi;
  logic [1:0]         an_hi;

  // Map an active-high segment pattern onto the board's drive polarity.
  function automatic logic [6:0] seg_drive(input logic [6:0] hi);
    return SEG_ACTIVE_LOW ? ~hi : hi;
  endfunction

  // Map active-high digit enables onto the board's drive polarity.
  function automatic logic [1:0] an_drive(input logic [1:0] hi);
    return SEG_ACTIVE_LOW ? ~hi : hi;
  endfunction

  // Slot sequencer: counter is reloaded on entry, the slot ends when it hits 1.
  // After reset the count is 0, so the first GAP_U is a single cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt - 1'b1;
    commit     = 1'b0;
    expire     = (cnt <= CNT_W'(1));
    case (state)
      GAP_U: if (expire) begin
        state_next = UNITS;
        cnt_next   = REFRESH_LD;
        commit     = 1'b1;
      end
      UNITS: if (expire) begin
        state_next = GAP_T;
        cnt_next   = GAP_LD;
      end
      GAP_T: if (expire) begin
        state_next = TENS;
        cnt_next   = REFRESH_LD;
      end
      TENS: if (expire) begin
        state_next = GAP_U;
        cnt_next   = GAP_LD;
      end
      default: begin
        state_next = GAP_U;
        cnt_next   = GAP_LD;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GAP_U;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Pending/committed value: a coincident load at the boundary commits the
  // old pending value and immediately re-arms pending with the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      committed     <= '0;
    end else begin
      if (commit && pending_valid)
        committed <= pending;
      if (load) begin
        pending       <= bcd_in;
        pending_valid <= 1'b1;
      end else if (commit) begin
        pending_valid <= 1'b0;
      end
    end
  end

  assign bcd_err = (committed[DIGIT_W-1:0] > 4'd9);

  seg7_encode u_enc (
    .digit   (digit_sel),
    .pattern (pattern)
  );

  // Select the digit for the current slot and gate the drive; the tens digit
  // goes fully dark (no anode either) when leading-zero blanking applies.
  always_comb begin
    digit_sel = committed[DIGIT_W-1:0];
    seg_hi    = SEG_OFF;
    an_hi     = 2'b00;
    case (state)
      UNITS: begin
        seg_hi = pattern;
        an_hi  = 2'b01;
      end
      TENS: begin
        digit_sel = {3'b000, committed[WORD_W-1]};
        if (!(blank_lz && !committed[WORD_W-1])) begin
          seg_hi = pattern;
          an_hi  = 2'b10;
        end
      end
      default: begin
        seg_hi = SEG_OFF;
        an_hi  = 2'b00;
      end
    endcase
  end

  // ---- output register stage: drive lags the state register by one cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      seg         <= seg_drive(SEG_OFF);
      an          <= an_drive(2'b00);
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_drive(seg_hi);
      an          <= an_drive(an_hi);
      frame_start <= commit;
    end
  end

endmodule
